// File: rtl/mem_arbiter.sv
// mem_arbiter: two-to-one arbiter between the instruction-fetch and data ports onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants under contention instead of data-first priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_read,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_resp,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [DATA_W/8-1:0] data_mbe,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_resp,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_mbe,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int MBE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

    state_t              r_state;
    logic                r_read;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [MBE_W-1:0]    r_mbe;
    logic [DATA_W-1:0]   r_wdata;

    logic w_instPend;
    logic w_dataPend;
    logic w_grantData;
    logic w_instDone;
    logic w_dataDone;

    assign w_instPend = inst_read;
    assign w_dataPend = data_read | data_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_lastData;

    // Under contention the side that did not win last time gets the grant.
    assign w_grantData = w_dataPend & (~w_instPend | ~r_lastData);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastData <= 1'b0;
        end else if (r_state == IDLE && (w_dataPend || w_instPend)) begin
            r_lastData <= w_grantData;
        end
    end
`else
    // Data belongs to the older instruction, so it always wins to avoid pipeline deadlock.
    assign w_grantData = w_dataPend;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_mbe   <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantData) begin
                        r_state <= DATA;
                        r_addr  <= data_addr;
                        r_mbe   <= data_mbe;
                        r_wdata <= data_wdata;
                        // A simultaneous read+write is treated as a write.
                        r_write <= data_write;
                        r_read  <= ~data_write;
                    end else if (w_instPend) begin
                        r_state <= INST;
                        r_addr  <= inst_addr;
                        r_mbe   <= '1;
                        r_wdata <= '0;
                        r_write <= 1'b0;
                        r_read  <= 1'b1;
                    end
                end
                INST, DATA: begin
                    if (mem_resp) begin
                        r_state <= IDLE;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_addr  <= '0;
                        r_mbe   <= '0;
                        r_wdata <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_instDone = (r_state == INST) & mem_resp;
    assign w_dataDone = (r_state == DATA) & mem_resp;

    assign inst_resp  = w_instDone;
    assign inst_rdata = w_instDone ? mem_rdata : '0;
    assign data_resp  = w_dataDone;
    assign data_rdata = w_dataDone ? mem_rdata : '0;

    assign mem_read   = r_read;
    assign mem_write  = r_write;
    assign mem_addr   = r_addr;
    assign mem_mbe    = r_mbe;
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case sequences and a
// randomized run against a transaction-level model. Honours MEM_ARB_ROUND_ROBIN_EN when defined.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    typedef struct {
        logic          rst;
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [MW-1:0] dm;
        logic [AW-1:0] da;
        logic [DW-1:0] dwd;
        logic          mr;
        logic [DW-1:0] mrd;
    } in_t;

    typedef struct {
        logic          r;
        logic          w;
        logic [AW-1:0] a;
        logic [MW-1:0] m;
        logic [DW-1:0] wd;
        logic          ir;
        logic [DW-1:0] ird;
        logic          dr;
        logic [DW-1:0] drd;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          instRead;
    logic [AW-1:0] instAddr;
    logic          instResp;
    logic [DW-1:0] instRdata;
    logic          dataRead;
    logic          dataWrite;
    logic [MW-1:0] dataMbe;
    logic [AW-1:0] dataAddr;
    logic [DW-1:0] dataWdata;
    logic          dataResp;
    logic [DW-1:0] dataRdata;
    logic          memRead;
    logic          memWrite;
    logic [MW-1:0] memMbe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic          memResp;
    logic [DW-1:0] memRdata;

    int checks = 0;
    int failures = 0;

    vec_t vecs[$];

    // Model of the transaction in flight, kept in terms of owner and request attributes.
    bit            mBusy;
    bit            mData;
    bit            mWrite;
    bit            mLastData;
    logic [AW-1:0] mAddr;
    logic [MW-1:0] mMbe;
    logic [DW-1:0] mWdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_read(instRead), .inst_addr(instAddr), .inst_resp(instResp), .inst_rdata(instRdata),
        .data_read(dataRead), .data_write(dataWrite), .data_mbe(dataMbe), .data_addr(dataAddr),
        .data_wdata(dataWdata), .data_resp(dataResp), .data_rdata(dataRdata),
        .mem_read(memRead), .mem_write(memWrite), .mem_mbe(memMbe), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_resp(memResp), .mem_rdata(memRdata)
    );

    function automatic in_t mkIn(logic r, logic ir, logic [AW-1:0] ia, logic dr, logic dw,
                                 logic [MW-1:0] dm, logic [AW-1:0] da, logic [DW-1:0] dwd,
                                 logic mr, logic [DW-1:0] mrd);
        in_t s;
        s.rst = r; s.ir = ir; s.ia = ia; s.dr = dr; s.dw = dw;
        s.dm = dm; s.da = da; s.dwd = dwd; s.mr = mr; s.mrd = mrd;
        return s;
    endfunction

    function automatic exp_t mkEx(logic r, logic w, logic [AW-1:0] a, logic [MW-1:0] m,
                                  logic [DW-1:0] wd, logic ir, logic [DW-1:0] ird,
                                  logic dr, logic [DW-1:0] drd);
        exp_t e;
        e.r = r; e.w = w; e.a = a; e.m = m; e.wd = wd;
        e.ir = ir; e.ird = ird; e.dr = dr; e.drd = drd;
        return e;
    endfunction

    function automatic exp_t zeroExp();
        return mkEx(0, 0, '0, '0, '0, 0, '0, 0, '0);
    endfunction

    task automatic addVec(input in_t s, input exp_t e);
        vec_t v;
        v.in = s;
        v.ex = e;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input in_t s);
        rst = s.rst; instRead = s.ir; instAddr = s.ia;
        dataRead = s.dr; dataWrite = s.dw; dataMbe = s.dm; dataAddr = s.da; dataWdata = s.dwd;
        memResp = s.mr; memRdata = s.mrd;
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", nm, act, exv);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input bit allFields);
        cmp({tag, " mem_read"},   32'(memRead),   32'(e.r));
        cmp({tag, " mem_write"},  32'(memWrite),  32'(e.w));
        cmp({tag, " inst_resp"},  32'(instResp),  32'(e.ir));
        cmp({tag, " inst_rdata"}, instRdata,      e.ird);
        cmp({tag, " data_resp"},  32'(dataResp),  32'(e.dr));
        cmp({tag, " data_rdata"}, dataRdata,      e.drd);
        if (allFields || e.r || e.w) begin
            cmp({tag, " mem_addr"}, memAddr,      e.a);
            cmp({tag, " mem_mbe"},  32'(memMbe),  32'(e.m));
        end
        if (allFields || e.w) begin
            cmp({tag, " mem_wdata"}, memWdata, e.wd);
        end
    endtask

    task automatic step(input string tag, input in_t s, input exp_t e, input bit allFields);
        applyStimulus(s);
        @(negedge clk);
        checkOutput(tag, e, allFields);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t modelPredict(input in_t s);
        exp_t e;
        e = zeroExp();
        if (mBusy) begin
            e.r = !mWrite; e.w = mWrite; e.a = mAddr; e.m = mMbe; e.wd = mWdata;
            if (s.mr && mData)  begin e.dr = 1'b1; e.drd = s.mrd; end
            if (s.mr && !mData) begin e.ir = 1'b1; e.ird = s.mrd; end
        end
        return e;
    endfunction

    task automatic modelEdge(input in_t s);
        bit dataPend;
        bit takeData;
        bit roundRobin;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        roundRobin = 1'b1;
`else
        roundRobin = 1'b0;
`endif
        dataPend = s.dr || s.dw;
        if (dataPend && s.ir) takeData = roundRobin ? !mLastData : 1'b1;
        else                  takeData = dataPend;
        if (s.rst) begin
            mBusy = 0; mLastData = 0;
        end else if (mBusy) begin
            if (s.mr) mBusy = 0;
        end else if (takeData) begin
            mBusy = 1; mData = 1; mWrite = s.dw; mAddr = s.da; mMbe = s.dm; mWdata = s.dwd;
            mLastData = 1;
        end else if (s.ir) begin
            mBusy = 1; mData = 0; mWrite = 0; mAddr = s.ia; mMbe = '1; mWdata = '0;
            mLastData = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        in_t  s;
        exp_t e;
        bit   expData;
        bit   instOn;
        bit   dataOn;
        logic [AW-1:0] rIa;
        logic [AW-1:0] rDa;
        logic          rDr;
        logic          rDw;
        logic [MW-1:0] rDm;
        logic [DW-1:0] rDwd;

        applyStimulus(mkIn(1, 0, '0, 0, 0, '0, '0, '0, 0, '0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Fetch, store with changing inputs, contention, stray response.
        addVec(mkIn(1, 0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0), zeroExp());
        addVec(mkIn(0, 1, 32'h60, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0), zeroExp());
        addVec(mkIn(0, 1, 32'h60, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0),
               mkEx(1, 0, 32'h60, 4'hF, 32'h0, 0, 32'h0, 0, 32'h0));
        addVec(mkIn(0, 1, 32'h60, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0),
               mkEx(1, 0, 32'h60, 4'hF, 32'h0, 0, 32'h0, 0, 32'h0));
        addVec(mkIn(0, 1, 32'h60, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h00A00093),
               mkEx(1, 0, 32'h60, 4'hF, 32'h0, 1, 32'h00A00093, 0, 32'h0));
        addVec(mkIn(0, 0, 32'h0, 0, 1, 4'hC, 32'h104, 32'hDEADBEEF, 0, 32'h0), zeroExp());
        addVec(mkIn(0, 0, 32'h0, 0, 1, 4'h3, 32'h200, 32'h12345678, 0, 32'h0),
               mkEx(0, 1, 32'h104, 4'hC, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0));
        addVec(mkIn(0, 0, 32'h0, 0, 1, 4'h3, 32'h200, 32'h12345678, 1, 32'h55555555),
               mkEx(0, 1, 32'h104, 4'hC, 32'hDEADBEEF, 0, 32'h0, 1, 32'h55555555));
        addVec(mkIn(0, 0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0), zeroExp());
        addVec(mkIn(1, 0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0), zeroExp());
        addVec(mkIn(0, 1, 32'h80, 1, 0, 4'hF, 32'h300, 32'h0, 0, 32'h0), zeroExp());
        addVec(mkIn(0, 1, 32'h80, 1, 0, 4'hF, 32'h300, 32'h0, 1, 32'h11112222),
               mkEx(1, 0, 32'h300, 4'hF, 32'h0, 0, 32'h0, 1, 32'h11112222));
        addVec(mkIn(0, 1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0), zeroExp());
        addVec(mkIn(0, 1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h33334444),
               mkEx(1, 0, 32'h80, 4'hF, 32'h0, 1, 32'h33334444, 0, 32'h0));
        addVec(mkIn(0, 0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0), zeroExp());
        addVec(mkIn(0, 0, 32'h0,  0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hFFFFFFFF), zeroExp());

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].in, vecs[i].ex, 1'b0);
        end

        // Reset during the second strobe cycle of a data read, then a late mem_resp.
        step("rstmid0", mkIn(0, 0, '0, 1, 0, 4'hF, 32'h400, '0, 0, '0), zeroExp(), 1'b0);
        step("rstmid1", mkIn(0, 0, '0, 1, 0, 4'hF, 32'h400, '0, 0, '0),
             mkEx(1, 0, 32'h400, 4'hF, '0, 0, '0, 0, '0), 1'b0);
        step("rstmid2", mkIn(1, 0, '0, 1, 0, 4'hF, 32'h400, '0, 0, '0),
             mkEx(1, 0, 32'h400, 4'hF, '0, 0, '0, 0, '0), 1'b0);
        step("rstmid3", mkIn(0, 0, '0, 0, 0, '0, '0, '0, 1, 32'hCAFEF00D), zeroExp(), 1'b1);
        step("rstmid4", mkIn(0, 1, 32'h90, 0, 0, '0, '0, '0, 0, '0), zeroExp(), 1'b0);
        step("rstmid5", mkIn(0, 1, 32'h90, 0, 0, '0, '0, '0, 1, 32'h1),
             mkEx(1, 0, 32'h90, 4'hF, '0, 1, 32'h1, 0, '0), 1'b0);

        // Stray responses straight after reset leave every output at zero.
        step("stray0", mkIn(1, 0, '0, 0, 0, '0, '0, '0, 0, '0), zeroExp(), 1'b1);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("stray%0d", k + 1), mkIn(0, 0, '0, 0, 0, '0, '0, '0, 1, 32'hA5A5A5A5),
                 zeroExp(), 1'b1);
        end

        // Both sides held through four zero-wait grants.
        step("cont_rst", mkIn(1, 0, '0, 0, 0, '0, '0, '0, 0, '0), zeroExp(), 1'b0);
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            expData = (g % 2 == 0);
`else
            expData = 1'b1;
`endif
            step($sformatf("cont%0d_idle", g), mkIn(0, 1, 32'hA0, 1, 0, 4'hF, 32'hB0, '0, 0, '0),
                 zeroExp(), 1'b0);
            step($sformatf("cont%0d_grant", g), mkIn(0, 1, 32'hA0, 1, 0, 4'hF, 32'hB0, '0, 1, 32'h100 + g),
                 mkEx(1, 0, expData ? 32'hB0 : 32'hA0, 4'hF, '0,
                      !expData, expData ? 32'h0 : 32'h100 + g,
                      expData,  expData ? 32'h100 + g : 32'h0), 1'b0);
        end

        // Randomized traffic against the transaction model.
        instOn = 0; dataOn = 0;
        rIa = '0; rDa = '0; rDr = 0; rDw = 0; rDm = '0; rDwd = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!instOn && ($urandom % 3 == 0)) begin
                instOn = 1;
                rIa = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            end else if (instOn && ($urandom % 25 == 0)) begin
                instOn = 0;
            end
            if (!dataOn && ($urandom % 3 == 0)) begin
                dataOn = 1;
                rDa = $urandom & 32'hFFFF_FFFC;
                case ($urandom % 10)
                    0:       begin rDr = 1; rDw = 1; end
                    1, 2, 3: begin rDr = 0; rDw = 1; end
                    default: begin rDr = 1; rDw = 0; end
                endcase
                rDm = 4'($urandom);
                rDwd = $urandom;
            end else if (dataOn && ($urandom % 25 == 0)) begin
                dataOn = 0;
            end else if (dataOn && ($urandom % 4 == 0)) begin
                rDwd = $urandom;
                rDm = 4'($urandom);
            end
            s = mkIn((c == 0) || ($urandom % 97 == 0), instOn, rIa, dataOn && rDr, dataOn && rDw,
                     rDm, rDa, rDwd, ($urandom % 3 == 0), $urandom);
            applyStimulus(s);
            @(negedge clk);
            e = modelPredict(s);
            if (c > 0) checkOutput($sformatf("rand%0d", c), e, 1'b0);
            @(posedge clk);
            modelEdge(s);
            #1;
            if (e.ir || s.rst) instOn = 0;
            if (e.dr || s.rst) dataOn = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
